fir_avg_n_u: RTL and testbench

- Parametrised successor to the team's fixed 4-tap unsigned averaging FIR.
- Generalised to TAPS taps and W-bit samples, with a valid-qualified input stream, a window-fill tracker and a synchronous flush.
- Uses a running-sum datapath: one add and one subtract per accepted sample, instead of an adder tree.
- Sits in the sample pipeline between the input sampler and the downstream decimator/scaler.

---
 rtl/fir_avg_n_u.sv | 105 ++++++++++
 tb/tb_fir_avg_n_u.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fir_avg_n_u.sv
// fir_avg_n_u: unsigned moving-sum FIR over the last TAPS accepted samples.
// Running-sum datapath: each accepted sample adds the new value and subtracts
// the one falling out of the delay line. The window can be flushed mid-stream
// with clear, and a fill counter tracks how many samples the window holds.
// Optional feature macro: FIR_AVG_MEAN_EN adds a rounded, saturated mean output.
// That output is only legal when TAPS is a power of two.
module fir_avg_n_u #(
    parameter int W    = 16,
    parameter int TAPS = 4,
    parameter int SW   = W + $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [W-1:0]                 a,
    input  logic                         clear,
    output logic [SW-1:0]                s,
    output logic                         out_valid,
    output logic [$clog2(TAPS+1)-1:0]    fill
`ifdef FIR_AVG_MEAN_EN
    ,
    output logic [W-1:0]                 mean
`endif
);

    localparam int FW = $clog2(TAPS + 1);

    if (TAPS < 2 || TAPS > 64) begin : g_taps_range
        $error("fir_avg_n_u: TAPS must be in 2..64");
    end

`ifdef FIR_AVG_MEAN_EN
    localparam int LOG2 = $clog2(TAPS);

    if ((TAPS & (TAPS - 1)) != 0) begin : g_taps_pow2
        $error("fir_avg_n_u: mean output needs TAPS to be a power of two");
    end

    // Divide by TAPS with round-half-up, clamped to the largest W-bit value.
    function automatic logic [W-1:0] round_sat(input logic [SW-1:0] v);
        logic [SW:0] t;
        t = {1'b0, v} + (SW+1)'(TAPS / 2);
        t = t >> LOG2;
        if (t > (SW+1)'({W{1'b1}}))
            return {W{1'b1}};
        else
            return t[W-1:0];
    endfunction
`endif

    logic [W-1:0]  line_p1 [TAPS];
    logic [SW-1:0] acc_p1;
    logic [FW-1:0] fill_p1;
    logic          vld_p1;

    logic [SW-1:0] acc_next;
    logic [FW-1:0] fill_next;
    logic          full_next;

    // Next-state arithmetic for one accepted sample. Computing in SW bits is
    // exact: the evicted value was added earlier, so the difference never
    // goes negative and the wraparound of the intermediate cancels out.
    always_comb begin
        acc_next  = acc_p1 + SW'(a) - SW'(line_p1[TAPS-1]);
        fill_next = (fill_p1 == FW'(TAPS)) ? fill_p1 : fill_p1 + 1'b1;
        full_next = (({1'b0, fill_p1} + 1'b1) >= (FW+1)'(TAPS));
    end

    // ---- stage p1: delay line, running sum, fill and window-valid pulse ----
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < TAPS; i++) line_p1[i] <= '0;
            acc_p1  <= '0;
            fill_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (in_valid) begin
            line_p1[0] <= a;
            for (int i = 1; i < TAPS; i++) line_p1[i] <= line_p1[i-1];
            acc_p1  <= acc_next;
            fill_p1 <= fill_next;
            vld_p1  <= full_next;
        end else begin
            vld_p1  <= 1'b0;
        end
    end

`ifdef FIR_AVG_MEAN_EN
    logic [W-1:0] mean_p1;

    // Mean register, updated in lockstep with the running sum.
    always_ff @(posedge clk) begin
        if (reset || clear)
            mean_p1 <= '0;
        else if (in_valid)
            mean_p1 <= round_sat(acc_next);
    end

    assign mean = mean_p1;
`endif

    assign s         = acc_p1;
    assign out_valid = vld_p1;
    assign fill      = fill_p1;

endmodule

// File: tb/tb_fir_avg_n_u.sv
// Directed bench for fir_avg_n_u: a TAPS=4/W=16 instance and a TAPS=8/W=12 instance.
module tb_fir_avg_n_u;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, clear2, in_valid2;
    logic [15:0] a;
    logic [11:0] a2;
    logic [17:0] s;
    logic [14:0] s2;
    logic        out_valid, out_valid2;
    logic [2:0]  fill;
    logic [3:0]  fill2;
`ifdef FIR_AVG_MEAN_EN
    logic [15:0] mean;
    logic [11:0] mean2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_avg_n_u #(.W(16), .TAPS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .clear(clear),
        .s(s), .out_valid(out_valid), .fill(fill)
`ifdef FIR_AVG_MEAN_EN
        , .mean(mean)
`endif
    );

    fir_avg_n_u #(.W(12), .TAPS(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .a(a2), .clear(clear2),
        .s(s2), .out_valid(out_valid2), .fill(fill2)
`ifdef FIR_AVG_MEAN_EN
        , .mean(mean2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs to the TAPS=4 instance; outputs are settled #1 after the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic clr, input logic rst);
        in_valid = v; a = d; clear = clr; reset = rst;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    endtask

    task automatic expect4(input string tag, input int es, input logic ev, input int ef);
        chk({tag, ".s"}, 32'(s), 32'(es));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".fill"}, 32'(fill), 32'(ef));
    endtask

    initial begin
        int fill_seq [4] = '{1, 2, 3, 4};
        int sum_seq  [4] = '{1, 3, 6, 10};
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; a = '0;
        clear2 = 1'b0; in_valid2 = 1'b0; a2 = '0;
        @(posedge clk); #1;
        step(1'b1, 16'd77, 1'b0, 1'b1);
        expect4("reset", 0, 1'b0, 0);

        // fill: 1,2,3,4
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'(i + 1), 1'b0, 1'b0);
            expect4($sformatf("fill%0d", i), sum_seq[i], (i == 3), fill_seq[i]);
        end
`ifdef FIR_AVG_MEAN_EN
        chk("mean_fill", 32'(mean), 32'd3);
`endif
        // sliding window
        step(1'b1, 16'd5, 1'b0, 1'b0);
        expect4("slide5", 14, 1'b1, 4);
        step(1'b1, 16'd6, 1'b0, 1'b0);
        expect4("slide6", 18, 1'b1, 4);
        step(1'b0, 16'd99, 1'b0, 1'b0);
        expect4("idle", 18, 1'b0, 4);

        // all-ones extreme
        for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
        expect4("maxval", 18'h3FFFC, 1'b1, 4);
`ifdef FIR_AVG_MEAN_EN
        chk("mean_max", 32'(mean), 32'hFFFF);
`endif

        // gapped input after a flush
        step(1'b0, 16'd0, 1'b1, 1'b0);
        expect4("flush", 0, 1'b0, 0);
        step(1'b1, 16'd10, 1'b0, 1'b0); expect4("gap10", 10, 1'b0, 1);
        step(1'b0, 16'd55, 1'b0, 1'b0); expect4("gapA", 10, 1'b0, 1);
        step(1'b1, 16'd20, 1'b0, 1'b0); expect4("gap20", 30, 1'b0, 2);
        step(1'b0, 16'd55, 1'b0, 1'b0); expect4("gapB", 30, 1'b0, 2);
        step(1'b0, 16'd55, 1'b0, 1'b0); expect4("gapC", 30, 1'b0, 2);
        step(1'b1, 16'd30, 1'b0, 1'b0); expect4("gap30", 60, 1'b0, 3);
        step(1'b1, 16'd40, 1'b0, 1'b0); expect4("gap40", 100, 1'b1, 4);
        step(1'b0, 16'd0, 1'b0, 1'b0);  expect4("gapD", 100, 1'b0, 4);

        // mid-stream clear drops the concurrent sample
        for (int i = 0; i < 4; i++) step(1'b1, 16'd7, 1'b0, 1'b0);
        expect4("sevens", 28, 1'b1, 4);
        step(1'b1, 16'd9, 1'b1, 1'b0);
        expect4("clear", 0, 1'b0, 0);
`ifdef FIR_AVG_MEAN_EN
        chk("mean_clear", 32'(mean), 32'd0);
`endif
        step(1'b1, 16'd5, 1'b0, 1'b0);
        expect4("after_clr", 5, 1'b0, 1);
        step(1'b1, 16'd3, 1'b0, 1'b0);
        expect4("after_clr2", 8, 1'b0, 2);

        // reset together with clear and a valid sample
        step(1'b1, 16'd3, 1'b1, 1'b1);
        expect4("rst_clr", 0, 1'b0, 0);

        // TAPS=8, W=12: eight samples of 100
        for (int i = 1; i <= 8; i++) begin
            in_valid2 = 1'b1; a2 = 12'd100;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            chk($sformatf("t8.s%0d", i), 32'(s2), 32'(100 * i));
            chk($sformatf("t8.ov%0d", i), 32'(out_valid2), 32'(i == 8));
            chk($sformatf("t8.fill%0d", i), 32'(fill2), 32'(i));
        end
`ifdef FIR_AVG_MEAN_EN
        chk("t8.mean", 32'(mean2), 32'd100);
`endif
        @(posedge clk); #1;
        chk("t8.idle_ov", 32'(out_valid2), 32'd0);
        chk("t8.idle_s", 32'(s2), 32'd800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
